// File: rtl/kernel_mul_pipe_hs.sv
// kernel_mul_pipe_hs: pipelined integer multiplier with valid/ready on both sides.
// Stage 1 captures the operands and their signedness flags. The product is
// formed combinationally from stage 1, and stages 2..NUM_STAGE carry the
// registered product. Each stage has its own valid bit, so bubbles collapse
// and the pipeline can hold up to NUM_STAGE beats under backpressure.
module kernel_mul_pipe_hs #(
  parameter int din0_WIDTH = 31,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 62,
  parameter int NUM_STAGE  = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din0_signed,
  input  logic                  din1_signed,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  busy
);

  // Exact product width of two operands that are each extended by one bit.
  localparam int PROD_W = din0_WIDTH + din1_WIDTH + 2;

  // v_q[0] is stage 1, v_q[NUM_STAGE-1] is the output stage.
  logic [NUM_STAGE-1:0] v_q;
  logic [NUM_STAGE-1:0] stage_ready;

  // Stage-1 operand registers.
  logic [din0_WIDTH-1:0] a_q;
  logic [din1_WIDTH-1:0] b_q;
  logic                  a_signed_q;
  logic                  b_signed_q;

  // Product datapath.
  logic signed [PROD_W-1:0] a_wide;
  logic signed [PROD_W-1:0] b_wide;
  logic signed [PROD_W-1:0] prod_full;
  logic [dout_WIDTH-1:0]    prod_res;

  // Ready chain in closed form: stage k may advance unless it and every stage
  // downstream of it are full while the consumer stalls. Written this way the
  // chain has no combinational self-reference.
  always_comb begin
    logic full_tail;
    // NOTE: every always_comb output gets a default before any conditional
    // logic so that no path leaves it unassigned and infers a latch.
    stage_ready = '0;
    full_tail   = 1'b1;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      full_tail      = full_tail & v_q[k];
      stage_ready[k] = dout_ready | ~full_tail;
    end
  end

  // Valid bits: each stage takes the upstream valid whenever it advances.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples the pre-edge value of its neighbour, not the updated one.
      if (stage_ready[0]) begin
        v_q[0] <= din_valid;
      end
      for (int k = 1; k < NUM_STAGE; k++) begin
        if (stage_ready[k]) begin
          v_q[k] <= v_q[k-1];
        end
      end
    end
  end

  // Stage-1 operand capture; holds unless a new beat is accepted.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      a_signed_q <= 1'b0;
      b_signed_q <= 1'b0;
    end else if (stage_ready[0] && din_valid) begin
      a_q        <= din0;
      b_q        <= din1;
      a_signed_q <= din0_signed;
      b_signed_q <= din1_signed;
    end
  end

  // Extend each operand by one bit (sign or zero per its flag), then widen to
  // the exact product width so the signed multiply needs no further extension.
  always_comb begin
    a_wide    = {{(PROD_W - din0_WIDTH){a_signed_q & a_q[din0_WIDTH-1]}}, a_q};
    b_wide    = {{(PROD_W - din1_WIDTH){b_signed_q & b_q[din1_WIDTH-1]}}, b_q};
    prod_full = a_wide * b_wide;
  end

  // Fit the exact product to the result width: wrap on truncation, sign-extend
  // when the result is wider than the exact product.
  if (dout_WIDTH <= PROD_W) begin : g_trunc
    assign prod_res = prod_full[dout_WIDTH-1:0];
  end else begin : g_sext
    assign prod_res = {{(dout_WIDTH - PROD_W){prod_full[PROD_W-1]}}, prod_full};
  end

  if (NUM_STAGE == 1) begin : g_comb_out
    // Single stage: the result is combinational from the operand registers.
    assign dout = prod_res;
  end else begin : g_reg_out
    // p_q[j] is the product register of stage j+2.
    logic [dout_WIDTH-1:0] p_q [NUM_STAGE-1];

    // Product stages: load only when the stage advances and upstream is valid,
    // so the output stage holds its value while stalled.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        // NOTE: this array is a handful of pipeline registers, not a RAM, so it
        // is reset like any other flop to make dout read 0 out of reset.
        for (int j = 0; j < NUM_STAGE - 1; j++) begin
          p_q[j] <= '0;
        end
      end else begin
        if (stage_ready[1] && v_q[0]) begin
          p_q[0] <= prod_res;
        end
        for (int j = 1; j < NUM_STAGE - 1; j++) begin
          if (stage_ready[j+1] && v_q[j]) begin
            p_q[j] <= p_q[j-1];
          end
        end
      end
    end

    assign dout = p_q[NUM_STAGE-2];
  end

  assign din_ready  = stage_ready[0];
  assign dout_valid = v_q[NUM_STAGE-1];
  assign busy       = |v_q;

endmodule

// File: doc/kernel_mul_pipe_hs.md
# kernel_mul_pipe_hs

Pipelined, parametrised integer multiplier with a valid/ready handshake on both sides and a per-transaction signedness mode for each operand. It succeeds the combinational unsigned multiplier cores in the HLS kernel datapath. It is used where the product feeds a stallable stream (accumulators, reduction trees), so the multiplier itself must absorb backpressure without dropping or duplicating results.

## Interface
- din0_WIDTH, 31: operand A width (≥1).
- din1_WIDTH, 32: operand B width (≥1).
- dout_WIDTH, 62: result width; result is the low dout_WIDTH bits of the exact product.
- NUM_STAGE, 3: pipeline register stages, ≥1; equals latency in cycles.
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- din_valid  in  1  operand beat valid.
- din_ready  out  1  block can accept a beat this cycle.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- din0_signed  in  1  1 = A is two's complement; 0 = unsigned.
- din1_signed  in  1  1 = B is two's complement; 0 = unsigned.
- dout_valid  out  1  result beat valid.
- dout_ready  in  1  downstream accepts the result.
- dout  out  dout_WIDTH  product, truncated or extended as described below.
- busy  out  1  OR of all stage valid bits.

## Operation
- A beat transfers on the input when din_valid && din_ready. It transfers on the output when dout_valid && dout_ready.
- Arithmetic: each operand is extended by one bit. The extension bit is the operand MSB when its signed flag is 1, else 0. The result is the signed product of the two (W+1)-bit values, exact width din0_WIDTH+din1_WIDTH+2.
- dout takes the low dout_WIDTH bits of that exact product. If dout_WIDTH exceeds the exact width, the product is sign-extended. Wrap-around on truncation is intentional; there is no saturation.
- Stage 1 registers din0, din1 and both sign flags. The multiply is computed from stage-1 registers. Stages 2..NUM_STAGE register the product.
  - NUM_STAGE=1: the product is combinational from stage 1 to dout.
  - dout is driven from the last stage.
- Each stage k has a valid bit v[k]. It advances when ready[k] = !v[k] || ready[k+1], where ready[NUM_STAGE+1] = dout_ready.
  - din_ready = ready[1].
  - dout_valid = v[NUM_STAGE].
- Bubbles collapse: a stalled output stage does not block empty upstream stages from filling.
- Capacity is NUM_STAGE beats. Ordering is strictly FIFO; no beat is lost or duplicated.
- Simultaneous input and output transfer when full: both happen, and occupancy is unchanged.
- Data registers of a stage load only when that stage advances. They hold otherwise, so dout is stable while dout_valid && !dout_ready.

## Timing
- Reset (ap_rst_n low, asynchronous assert, synchronous-to-ap_clk deassert handled upstream):
  - All v[k] = 0 and all data registers = 0.
  - dout_valid = 0, dout = 0, busy = 0.
  - din_ready = 1 combinationally from reset, since all stages are empty.
- Reset mid-operation discards every in-flight beat. No result from before reset appears afterwards.
- Latency: a beat accepted at edge n appears with dout_valid=1 after edge n+NUM_STAGE-1, i.e. NUM_STAGE cycles, when unstalled.
- Throughput: one beat per cycle with dout_ready held 1.
- din_ready depends combinationally on dout_ready through the ready chain. It does not depend on din_valid.
- dout, dout_valid and busy are register outputs. The exception is dout for NUM_STAGE=1, which is combinational from stage-1 registers.

## Test plan
Defaults: 31/32/62, NUM_STAGE=3.

1. Unsigned maximum: din0=0x7FFFFFFF, din1=0xFFFFFFFF, both flags 0, dout_ready=1 -> dout=0x3FFFFFFE80000001, with dout_valid exactly 3 cycles after acceptance.
2. Signed: din0=0x7FFFFFFF (−1), din1=0x00000005, both flags 1 -> dout=0x3FFFFFFFFFFFFFFB.
3. Mixed: din0=0x7FFFFFFF with din0_signed=1, din1=0xFFFFFFFF with din1_signed=0 -> dout=0x3FFFFFFF00000001.
4. Backpressure: stream 8 beats (din0=i, din1=i+1, unsigned) with dout_ready=0 for cycles 2–6. Required:
   - din_ready falls once 3 beats are held.
   - dout is stable during the stall.
   - All 8 products i·(i+1) emerge in order with no gaps after release.
   - Occupancy never exceeds 3.
5. Bubble collapse: one beat in, dout_ready=0 -> the beat reaches the last stage after 3 cycles and din_ready stays 1. Two more beats are accepted, then din_ready=0. Setting dout_ready=1 with din_valid=1 then transfers on both sides in the same cycle.
6. Reset mid-stream: pulse ap_rst_n low asynchronously with 3 beats in flight -> dout_valid=0, dout=0, busy=0 immediately. No stale result afterwards, and the next beat completes with normal latency.
